data_mem_resp: RTL and testbench



---
 rtl/data_mem_resp.sv | 135 +++++++++++++
 tb/tb_data_mem_resp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-addressable word array with byte-lane stores,
// formatted loads with registered output, and rejected-request detection/counting.
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  input  logic [2:0]  xfer_size,
  output logic [31:0] read_data,
  output logic        rd_valid,
  output logic        err,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    XF_B  = 3'b000,
    XF_H  = 3'b001,
    XF_W  = 3'b010,
    XF_BU = 3'b100,
    XF_HU = 3'b101
  } xfer_e;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             out_of_range;
  logic             misaligned;
  logic             illegal_type;
  logic             conflict;
  logic             req;
  logic             rejected;
  logic             do_load;
  logic             do_store;
  logic [3:0]       byte_en;
  logic [31:0]      wr_lanes;

  logic [31:0]      ld_word;
  xfer_e            ld_size;
  logic [1:0]       ld_off;
  logic             ld_pend;
  logic             err_pend;
  logic [31:0]      shifted;
  logic [31:0]      fmt_data;

  // Request decode
  always_comb begin
    idx          = address[IDX_W+1:2];
    off          = address[1:0];
    out_of_range = |address[31:IDX_W+2];
    conflict     = read_enable & write_enable;
    req          = read_enable | write_enable;
    misaligned   = 1'b0;
    illegal_type = 1'b0;
    byte_en      = '0;
    wr_lanes     = write_data;
    case (xfer_size)
      XF_B: begin
        byte_en  = 4'b0001 << off;
        wr_lanes = {4{write_data[7:0]}};
      end
      XF_H: begin
        misaligned = off[0];
        byte_en    = 4'b0011 << off;
        wr_lanes   = {2{write_data[15:0]}};
      end
      XF_W: begin
        misaligned = (off != 2'b00);
        byte_en    = '1;
      end
      XF_BU:   illegal_type = write_enable;
      XF_HU: begin
        misaligned   = off[0];
        illegal_type = write_enable;
      end
      default: illegal_type = 1'b1;
    endcase
    rejected = out_of_range | misaligned | illegal_type | conflict;
    do_load  = read_enable  & ~write_enable & ~rejected;
    do_store = write_enable & ~read_enable  & ~rejected;
  end

  // Array: never reset; a request coincident with Reset is dropped
  always_ff @(posedge CLK) begin
    if (!Reset && do_store) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (byte_en[l]) mem[idx][8*l +: 8] <= wr_lanes[8*l +: 8];
      end
    end
    if (!Reset && do_load) ld_word <= mem[idx];
  end

  // Load formatting from the registered size/offset copies
  always_comb begin
    shifted  = ld_word >> {ld_off, 3'b000};
    fmt_data = shifted;
    case (ld_size)
      XF_B:    fmt_data = {{24{shifted[7]}}, shifted[7:0]};
      XF_BU:   fmt_data = {24'h0, shifted[7:0]};
      XF_H:    fmt_data = {{16{shifted[15]}}, shifted[15:0]};
      XF_HU:   fmt_data = {16'h0, shifted[15:0]};
      default: fmt_data = ld_word;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ld_pend   <= 1'b0;
      err_pend  <= 1'b0;
      ld_size   <= XF_W;
      ld_off    <= '0;
      read_data <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      ld_pend  <= do_load;
      err_pend <= req & rejected;
      if (do_load) begin
        ld_size <= xfer_e'(xfer_size);
        ld_off  <= off;
      end
      rd_valid <= ld_pend;
      err      <= err_pend;
      if (ld_pend) read_data <= fmt_data;
      if (err_pend && err_count != '1) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed, table-driven bench for data_mem_resp with hand sequences for
// saturation, reset persistence, back-to-back loads and read-after-write.
module tb_data_mem_resp;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] address;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] write_data;
  logic [2:0]  xfer_size;
  logic [31:0] read_data;
  logic        rd_valid;
  logic        err;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_resp #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .address     (address),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .write_data  (write_data),
    .xfer_size   (xfer_size),
    .read_data   (read_data),
    .rd_valid    (rd_valid),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    xfer_size    = W;
  endtask

  function automatic vec_t mk(input logic rst, input logic re, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] size, input logic ev,
                              input logic [31:0] ed, input logic ee, input logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.re = re; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
    v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee; v.exp_cnt = ec;
    return v;
  endfunction

  // One request for one cycle, one idle cycle, then check the registered outputs
  task automatic apply(input vec_t v, input int i);
    Reset        = v.rst;
    read_enable  = v.re;
    write_enable = v.we;
    address      = v.addr;
    write_data   = v.wdata;
    xfer_size    = v.size;
    @(posedge CLK); #1;
    Reset = 1'b0;
    idle_inputs();
    @(posedge CLK); #1;
    check($sformatf("v%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, v.exp_valid});
    check($sformatf("v%0d read_data", i), read_data, v.exp_data);
    check($sformatf("v%0d err", i), {31'b0, err}, {31'b0, v.exp_err});
    check($sformatf("v%0d err_count", i), {24'b0, err_count}, {24'b0, v.exp_cnt});
  endtask

  logic [31:0] b2b_exp [3];

  initial begin
    // rst re we addr wdata size | valid data err cnt
    vecs.push_back(mk(0,0,1,32'h40,32'h8badf00d,W,  0,32'h0,0,0));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,W,         1,32'h8badf00d,0,0));
    vecs.push_back(mk(0,1,0,32'h43,32'h0,B,         1,32'hffffff8b,0,0));
    vecs.push_back(mk(0,1,0,32'h43,32'h0,BU,        1,32'h0000008b,0,0));
    vecs.push_back(mk(0,1,0,32'h42,32'h0,H,         1,32'hffff8bad,0,0));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,HU,        1,32'h0000f00d,0,0));
    vecs.push_back(mk(0,0,1,32'h41,32'h12,B,        0,32'h0000f00d,0,0));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,W,         1,32'h8bad120d,0,0));
    vecs.push_back(mk(0,0,1,32'h42,32'h0000beef,H,  0,32'h8bad120d,0,0));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,W,         1,32'hbeef120d,0,0));
    vecs.push_back(mk(0,1,0,32'h41,32'h0,W,         0,32'hbeef120d,1,1));
    vecs.push_back(mk(0,0,1,32'h43,32'h5555,H,      0,32'hbeef120d,1,2));
    vecs.push_back(mk(0,1,0,32'h1000,32'h0,W,       0,32'hbeef120d,1,3));
    vecs.push_back(mk(0,1,1,32'h40,32'h0,W,         0,32'hbeef120d,1,4));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,W,         1,32'hbeef120d,0,4));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,H,         1,32'h0000120d,0,4));
    vecs.push_back(mk(0,1,0,32'h42,32'h0,B,         1,32'hffffffef,0,4));
    vecs.push_back(mk(0,1,0,32'h42,32'h0,H,         1,32'hffffbeef,0,4));
    vecs.push_back(mk(0,1,0,32'h42,32'h0,HU,        1,32'h0000beef,0,4));
    vecs.push_back(mk(0,0,1,32'h40,32'hffffffff,BU, 0,32'h0000beef,1,5));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,3'b011,    0,32'h0000beef,1,6));
    vecs.push_back(mk(0,0,0,32'h40,32'h0,3'b111,    0,32'h0000beef,0,6));
    vecs.push_back(mk(0,1,0,32'h40,32'h0,W,         1,32'hbeef120d,0,6));
    vecs.push_back(mk(0,0,1,32'h44,32'h22222222,W,  0,32'hbeef120d,0,6));
    vecs.push_back(mk(1,0,1,32'h44,32'h11111111,W,  0,32'h0,0,0));
    vecs.push_back(mk(0,1,0,32'h44,32'h0,W,         1,32'h22222222,0,0));

    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    check("reset read_data", read_data, 32'h0);
    check("reset rd_valid", {31'b0, rd_valid}, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    check("reset err_count", {24'b0, err_count}, 32'h0);
    Reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Saturation: 300 illegal-type loads, one per cycle
    for (int i = 0; i < 300; i++) begin
      read_enable = 1'b1;
      address     = 32'h40;
      xfer_size   = 3'b111;
      @(posedge CLK); #1;
    end
    idle_inputs();
    @(posedge CLK); #1;
    check("sat err_count", {24'b0, err_count}, 32'd255);
    check("sat err", {31'b0, err}, 32'h1);
    check("sat read_data", read_data, 32'h22222222);

    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    check("post-reset err_count", {24'b0, err_count}, 32'h0);
    check("post-reset read_data", read_data, 32'h0);

    apply(mk(0,1,0,32'h40,32'h0,W, 1,32'hbeef120d,0,0), 100);

    // Back-to-back loads: one result per cycle
    b2b_exp[0] = 32'hbeef120d;
    b2b_exp[1] = 32'hffffffbe;
    b2b_exp[2] = 32'h0000beef;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i == 0) begin read_enable = 1'b1; address = 32'h40; xfer_size = W;  end
      if (i == 1) begin read_enable = 1'b1; address = 32'h43; xfer_size = B;  end
      if (i == 2) begin read_enable = 1'b1; address = 32'h42; xfer_size = HU; end
      @(posedge CLK); #1;
      if (i >= 1) begin
        check($sformatf("b2b%0d rd_valid", i-1), {31'b0, rd_valid}, 32'h1);
        check($sformatf("b2b%0d read_data", i-1), read_data, b2b_exp[i-1]);
      end
    end
    idle_inputs();
    @(posedge CLK); #1;
    check("b2b last", read_data, b2b_exp[2]);
    check("b2b end rd_valid", {31'b0, rd_valid}, 32'h0);

    // Read-after-write on consecutive cycles
    write_enable = 1'b1; address = 32'h48; write_data = 32'hcafe0001; xfer_size = W;
    @(posedge CLK); #1;
    idle_inputs();
    read_enable = 1'b1; address = 32'h48; xfer_size = W;
    @(posedge CLK); #1;
    idle_inputs();
    @(posedge CLK); #1;
    check("raw rd_valid", {31'b0, rd_valid}, 32'h1);
    check("raw read_data", read_data, 32'hcafe0001);
    check("raw err_count", {24'b0, err_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
